// File: rtl/ddr_svc_mc.sv
`default_nettype none
// ============================================================================
// Module      : ddr_svc_mc
// Description : Multi-channel DDR service port. Round-robin arbitration of
//               toggle-handshaked read/write burst requests onto a single
//               64-bit Avalon-MM burst master.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_svc_mc #(
   parameter int CHANNELS = 4,
   parameter int BURST_W  = 8
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      ram_waitrequest,
   output logic [BURST_W-1:0]        ram_burstcnt,
   output logic [28:0]               ram_addr,
   input  logic [63:0]               ram_readdata,
   input  logic                      ram_read_ready,
   output logic                      ram_read,
   output logic                      ram_write,
   output logic [63:0]               ram_writedata,
   output logic [7:0]                ram_byteenable,
   input  logic [CHANNELS*29-1:0]    ch_addr,
   input  logic [CHANNELS*BURST_W-1:0] ch_burst,
   input  logic [CHANNELS-1:0]       ch_we,
   input  logic [CHANNELS-1:0]       ch_req,
   output logic [CHANNELS-1:0]       ch_ack,
   input  logic [CHANNELS*64-1:0]    ch_wdata,
   input  logic [CHANNELS*8-1:0]     ch_be,
   output logic [CHANNELS-1:0]       ch_wnext,
   output logic [63:0]               ch_data,
   output logic [CHANNELS-1:0]       ch_ready
);

   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_WR   = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [CW-1:0]       rr_q, rr_d;
   logic [CW-1:0]       gnt_q, gnt_d;
   logic [28:0]         addr_q, addr_d;
   logic [BURST_W-1:0]  burst_q, burst_d;
   logic [BURST_W-1:0]  cnt_q, cnt_d;
   logic                read_q, read_d;
   logic                write_q, write_d;
   logic [CHANNELS-1:0] ack_q, ack_d;
   logic [CHANNELS-1:0] ready_q, ready_d;
   logic [63:0]         data_q, data_d;

   logic [28:0]         addr_a  [CHANNELS];
   logic [BURST_W-1:0]  burst_a [CHANNELS];
   logic [63:0]         wdata_a [CHANNELS];
   logic [7:0]          be_a    [CHANNELS];

   logic [CHANNELS-1:0] pend;
   logic                gnt_vld;
   logic [CW-1:0]       gnt_idx;
   logic [CW-1:0]       cand;
   logic [BURST_W-1:0]  cnt_inc;
   logic                beat_acc;

   // Split the flat per-channel buses into indexable arrays.
   for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
      assign addr_a[i]  = ch_addr[i*29 +: 29];
      assign burst_a[i] = ch_burst[i*BURST_W +: BURST_W];
      assign wdata_a[i] = ch_wdata[i*64 +: 64];
      assign be_a[i]    = ch_be[i*8 +: 8];
   end

   assign pend     = ch_req ^ ack_q;
   assign cnt_inc  = cnt_q + 1'b1;
   assign beat_acc = write_q & ~ram_waitrequest;

   // Round-robin search: first pending channel at or after the pointer.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         cand = CW'((int'(rr_q) + k) % CHANNELS);
         if (!gnt_vld && pend[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   // State and datapath registers; reset aborts any transaction at once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         rr_q    <= '0;
         gnt_q   <= '0;
         addr_q  <= '0;
         burst_q <= '0;
         cnt_q   <= '0;
         read_q  <= 1'b0;
         write_q <= 1'b0;
         ack_q   <= '0;
         ready_q <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         gnt_q   <= gnt_d;
         addr_q  <= addr_d;
         burst_q <= burst_d;
         cnt_q   <= cnt_d;
         read_q  <= read_d;
         write_q <= write_d;
         ack_q   <= ack_d;
         ready_q <= ready_d;
         data_q  <= data_d;
      end
   end

   // Next-state logic: grant and latch in IDLE, count beats in RD/WR.
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      gnt_d   = gnt_q;
      addr_d  = addr_q;
      burst_d = burst_q;
      cnt_d   = cnt_q;
      read_d  = read_q;
      write_d = write_q;
      ack_d   = ack_q;
      ready_d = '0;
      data_d  = data_q;
      case (state_q)
         S_IDLE: begin
            if (gnt_vld) begin
               gnt_d   = gnt_idx;
               addr_d  = addr_a[gnt_idx];
               burst_d = burst_a[gnt_idx];
               cnt_d   = '0;
               rr_d    = (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
               // Zero-length bursts complete without touching the DDR.
               if (burst_a[gnt_idx] == '0) begin
                  ack_d[gnt_idx] = ~ack_q[gnt_idx];
               end else if (ch_we[gnt_idx]) begin
                  write_d = 1'b1;
                  state_d = S_WR;
               end else begin
                  read_d  = 1'b1;
                  state_d = S_RD;
               end
            end
         end
         S_RD: begin
            if (read_q && !ram_waitrequest) begin
               read_d = 1'b0;
            end
            // Read beats are captured independently of the command stall.
            if (ram_read_ready) begin
               data_d         = ram_readdata;
               ready_d[gnt_q] = 1'b1;
               cnt_d          = cnt_inc;
               if (cnt_inc == burst_q) begin
                  ack_d[gnt_q] = ~ack_q[gnt_q];
                  read_d       = 1'b0;
                  state_d      = S_IDLE;
               end
            end
         end
         S_WR: begin
            if (beat_acc) begin
               cnt_d = cnt_inc;
               if (cnt_inc == burst_q) begin
                  ack_d[gnt_q] = ~ack_q[gnt_q];
                  write_d      = 1'b0;
                  state_d      = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output logic: write-beat pull strobe and write data mux of the grant.
   always_comb begin
      ch_wnext = '0;
      if (state_q == S_WR) begin
         ch_wnext[gnt_q] = beat_acc;
      end
      ram_writedata  = wdata_a[gnt_q];
      ram_byteenable = be_a[gnt_q];
   end

   assign ram_burstcnt = burst_q;
   assign ram_addr     = addr_q;
   assign ram_read     = read_q;
   assign ram_write    = write_q;
   assign ch_ack       = ack_q;
   assign ch_ready     = ready_q;
   assign ch_data      = data_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr_svc_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr_svc_mc
// Description : Directed self-checking bench for ddr_svc_mc (4 channels).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_svc_mc;

   localparam int CH = 4;
   localparam int BW = 8;

   logic            clk;
   logic            reset_n;
   logic            ram_waitrequest;
   logic [BW-1:0]   ram_burstcnt;
   logic [28:0]     ram_addr;
   logic [63:0]     ram_readdata;
   logic            ram_read_ready;
   logic            ram_read;
   logic            ram_write;
   logic [63:0]     ram_writedata;
   logic [7:0]      ram_byteenable;
   logic [CH*29-1:0] ch_addr;
   logic [CH*BW-1:0] ch_burst;
   logic [CH-1:0]   ch_we;
   logic [CH-1:0]   ch_req;
   logic [CH-1:0]   ch_ack;
   logic [CH*64-1:0] ch_wdata;
   logic [CH*8-1:0] ch_be;
   logic [CH-1:0]   ch_wnext;
   logic [63:0]     ch_data;
   logic [CH-1:0]   ch_ready;

   int total = 0;
   int bad   = 0;
   int wnext_cnt = 0;

   ddr_svc_mc #(.CHANNELS(CH), .BURST_W(BW)) dut (
      .clk(clk), .reset_n(reset_n),
      .ram_waitrequest(ram_waitrequest), .ram_burstcnt(ram_burstcnt),
      .ram_addr(ram_addr), .ram_readdata(ram_readdata),
      .ram_read_ready(ram_read_ready), .ram_read(ram_read),
      .ram_write(ram_write), .ram_writedata(ram_writedata),
      .ram_byteenable(ram_byteenable), .ch_addr(ch_addr),
      .ch_burst(ch_burst), .ch_we(ch_we), .ch_req(ch_req),
      .ch_ack(ch_ack), .ch_wdata(ch_wdata), .ch_be(ch_be),
      .ch_wnext(ch_wnext), .ch_data(ch_data), .ch_ready(ch_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count channel-2 write pulls seen at each active edge.
   always @(posedge clk) begin
      if (ch_wnext[2]) wnext_cnt <= wnext_cnt + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int i, input logic [28:0] a, input logic [7:0] b, input logic we);
      ch_addr[i*29 +: 29] = a;
      ch_burst[i*BW +: BW] = b;
      ch_we[i] = we;
   endtask

   task automatic set_wbeat(input logic [63:0] d, input logic [7:0] be);
      ch_wdata[2*64 +: 64] = d;
      ch_be[2*8 +: 8] = be;
   endtask

   initial begin
      reset_n = 1'b0;
      ram_waitrequest = 1'b0;
      ram_readdata = '0;
      ram_read_ready = 1'b0;
      ch_addr = '0;
      ch_burst = '0;
      ch_we = '0;
      ch_req = '0;
      ch_wdata = '0;
      ch_be = '0;
      #2;
      chk("rst_read",   64'(ram_read), 64'd0);
      chk("rst_write",  64'(ram_write), 64'd0);
      chk("rst_addr",   64'(ram_addr), 64'd0);
      chk("rst_burst",  64'(ram_burstcnt), 64'd0);
      chk("rst_ack",    64'(ch_ack), 64'd0);
      chk("rst_ready",  64'(ch_ready), 64'd0);
      chk("rst_data",   ch_data, 64'd0);
      chk("rst_wnext",  64'(ch_wnext), 64'd0);
      cyc(); cyc();
      @(negedge clk);
      reset_n = 1'b1;
      cyc();

      // ---- Read: ch1 burst 4 at 0x1000 ----
      set_ch(1, 29'h1000, 8'd4, 1'b0);
      ch_req[1] = 1'b1;
      cyc();
      chk("rd_cmd", 64'(ram_read), 64'd1);
      chk("rd_burstcnt", 64'(ram_burstcnt), 64'd4);
      chk("rd_addr", 64'(ram_addr), 64'h1000);
      for (int k = 0; k < 4; k++) begin
         ram_read_ready = 1'b1;
         ram_readdata = 64'hD0D0_0000_0000_0000 + 64'(k);
         cyc();
         chk("rd_cmd_drop", 64'(ram_read), 64'd0);
         chk("rd_ready", 64'(ch_ready), 64'b0010);
         chk("rd_data", ch_data, 64'hD0D0_0000_0000_0000 + 64'(k));
         chk("rd_ack", 64'(ch_ack), (k == 3) ? 64'b0010 : 64'b0000);
      end
      ram_read_ready = 1'b0;
      cyc();
      chk("rd_ready_end", 64'(ch_ready), 64'd0);

      // ---- Burst 0 on ch3: moves rr to 0 ----
      set_ch(3, 29'h0777, 8'd0, 1'b0);
      ch_req[3] = 1'b1;
      cyc();
      chk("b0_ack", 64'(ch_ack), 64'b1010);
      chk("b0_noread", 64'(ram_read), 64'd0);
      chk("b0_nowrite", 64'(ram_write), 64'd0);
      cyc();
      chk("b0_noread2", 64'(ram_read), 64'd0);

      // ---- Round-robin: ch0, ch2, ch3 together ----
      set_ch(0, 29'h0100, 8'd1, 1'b0);
      set_ch(2, 29'h0200, 8'd1, 1'b0);
      set_ch(3, 29'h0300, 8'd1, 1'b0);
      ch_req = ch_req ^ 4'b1101;
      cyc();
      chk("rr_g0_addr", 64'(ram_addr), 64'h0100);
      ram_read_ready = 1'b1; ram_readdata = 64'hA0;
      cyc();
      chk("rr_g0_ready", 64'(ch_ready), 64'b0001);
      chk("rr_g0_ack", 64'(ch_ack), 64'b1011);
      ram_read_ready = 1'b0;
      cyc();
      chk("rr_g2_addr", 64'(ram_addr), 64'h0200);
      chk("rr_g2_cmd", 64'(ram_read), 64'd1);
      set_ch(0, 29'h0180, 8'd1, 1'b0);
      ch_req[0] = ~ch_req[0];
      ram_read_ready = 1'b1; ram_readdata = 64'hA2;
      cyc();
      chk("rr_g2_ready", 64'(ch_ready), 64'b0100);
      chk("rr_g2_data", ch_data, 64'hA2);
      chk("rr_g2_ack", 64'(ch_ack), 64'b1111);
      ram_read_ready = 1'b0;
      cyc();
      chk("rr_g3_addr", 64'(ram_addr), 64'h0300);
      ram_read_ready = 1'b1; ram_readdata = 64'hA3;
      cyc();
      chk("rr_g3_ready", 64'(ch_ready), 64'b1000);
      chk("rr_g3_ack", 64'(ch_ack), 64'b0111);
      ram_read_ready = 1'b0;
      cyc();
      chk("rr_g0b_addr", 64'(ram_addr), 64'h0180);
      ram_read_ready = 1'b1; ram_readdata = 64'hA4;
      cyc();
      chk("rr_g0b_ready", 64'(ch_ready), 64'b0001);
      chk("rr_g0b_ack", 64'(ch_ack), 64'b0110);
      ram_read_ready = 1'b0;
      cyc();

      // ---- Write with stalls: ch2 burst 3 ----
      wnext_cnt = 0;
      set_ch(2, 29'h2000, 8'd3, 1'b1);
      set_wbeat(64'h1111_0000_0000_0001, 8'hFF);
      ch_req[2] = ~ch_req[2];
      cyc();
      chk("wr_cmd", 64'(ram_write), 64'd1);
      chk("wr_addr", 64'(ram_addr), 64'h2000);
      chk("wr_burstcnt", 64'(ram_burstcnt), 64'd3);
      chk("wr_wnext0", 64'(ch_wnext), 64'b0100);
      chk("wr_data0", ram_writedata, 64'h1111_0000_0000_0001);
      chk("wr_be0", 64'(ram_byteenable), 64'hFF);
      cyc();
      set_wbeat(64'h2222_0000_0000_0002, 8'h0F);
      ram_waitrequest = 1'b1;
      #1;
      chk("wr_stall_wnext", 64'(ch_wnext), 64'd0);
      chk("wr_data1", ram_writedata, 64'h2222_0000_0000_0002);
      chk("wr_be1", 64'(ram_byteenable), 64'h0F);
      cyc();
      chk("wr_stall_hold", 64'(ram_write), 64'd1);
      cyc();
      ram_waitrequest = 1'b0;
      #1;
      chk("wr_wnext1", 64'(ch_wnext), 64'b0100);
      cyc();
      set_wbeat(64'h3333_0000_0000_0003, 8'hF0);
      #1;
      chk("wr_data2", ram_writedata, 64'h3333_0000_0000_0003);
      chk("wr_be2", 64'(ram_byteenable), 64'hF0);
      cyc();
      chk("wr_drop", 64'(ram_write), 64'd0);
      chk("wr_ack", 64'(ch_ack), 64'b0010);
      chk("wr_wnext_idle", 64'(ch_wnext), 64'd0);
      chk("wr_pulses", 64'(wnext_cnt), 64'd3);

      // ---- Read with command stall: ch1 burst 4, 5 stalled cycles ----
      set_ch(1, 29'h3000, 8'd4, 1'b0);
      ch_req[1] = ~ch_req[1];
      ram_waitrequest = 1'b1;
      cyc();
      chk("rs_cmd", 64'(ram_read), 64'd1);
      ram_read_ready = 1'b1; ram_readdata = 64'hE0;
      cyc();
      chk("rs_hold_a", 64'(ram_read), 64'd1);
      chk("rs_data0", ch_data, 64'hE0);
      chk("rs_ready0", 64'(ch_ready), 64'b0010);
      ram_readdata = 64'hE1;
      cyc();
      chk("rs_data1", ch_data, 64'hE1);
      ram_read_ready = 1'b0;
      cyc();
      chk("rs_gap_ready", 64'(ch_ready), 64'd0);
      chk("rs_hold_c", 64'(ram_read), 64'd1);
      ram_read_ready = 1'b1; ram_readdata = 64'hE2;
      cyc();
      chk("rs_data2", ch_data, 64'hE2);
      ram_read_ready = 1'b0;
      cyc();
      chk("rs_hold_e", 64'(ram_read), 64'd1);
      chk("rs_ack_pend", 64'(ch_ack), 64'b0010);
      ram_waitrequest = 1'b0;
      ram_read_ready = 1'b1; ram_readdata = 64'hE3;
      cyc();
      chk("rs_cmd_drop", 64'(ram_read), 64'd0);
      chk("rs_data3", ch_data, 64'hE3);
      chk("rs_ack", 64'(ch_ack), 64'b0000);
      ram_read_ready = 1'b0;
      cyc();

      // ---- Reset mid-burst: ch0 burst 8, reset after 2 beats ----
      set_ch(0, 29'h4000, 8'd8, 1'b0);
      ch_req[0] = ~ch_req[0];
      cyc();
      chk("rm_cmd", 64'(ram_read), 64'd1);
      ram_read_ready = 1'b1; ram_readdata = 64'hF0;
      cyc();
      ram_readdata = 64'hF1;
      cyc();
      chk("rm_data1", ch_data, 64'hF1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rm_read", 64'(ram_read), 64'd0);
      chk("rm_addr", 64'(ram_addr), 64'd0);
      chk("rm_burst", 64'(ram_burstcnt), 64'd0);
      chk("rm_ready", 64'(ch_ready), 64'd0);
      chk("rm_data", ch_data, 64'd0);
      chk("rm_ack", 64'(ch_ack), 64'd0);
      ch_req = '0;
      cyc();
      @(negedge clk);
      reset_n = 1'b1;
      ram_readdata = 64'hF2;
      cyc();
      chk("rm_stray_ready", 64'(ch_ready), 64'd0);
      chk("rm_stray_data", ch_data, 64'd0);
      ram_read_ready = 1'b0;
      set_ch(0, 29'h5000, 8'd1, 1'b0);
      ch_req[0] = 1'b1;
      cyc();
      chk("rm_new_cmd", 64'(ram_read), 64'd1);
      chk("rm_new_addr", 64'(ram_addr), 64'h5000);
      ram_read_ready = 1'b1; ram_readdata = 64'h55;
      cyc();
      chk("rm_new_ready", 64'(ch_ready), 64'b0001);
      chk("rm_new_data", ch_data, 64'h55);
      chk("rm_new_ack", 64'(ch_ack), 64'b0001);
      ram_read_ready = 1'b0;
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ddr_svc_mc.md
# ddr_svc_mc

Parametrised multi-channel DDR service port for the sys layer: arbitrates up to CHANNELS client channels onto one 64-bit Avalon-MM burst master toward the HPS DDR bridge. Each channel issues toggle-handshaked read or write bursts. Channels are served round-robin. Read beats are returned on a shared data bus with per-channel strobes, and write beats are pulled from the granted channel. Read-data capture is decoupled from waitrequest, and a completion toggle is provided per channel.

## Interface
- CHANNELS, 4: number of client channels, 1..8.
- BURST_W, 8: burst-length field width; max burst 2^BURST_W-1.
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ram_waitrequest  in  1  Avalon stall.
- ram_burstcnt  out  BURST_W  burst length of current command.
- ram_addr  out  29  64-bit word address.
- ram_readdata  in  64  read beat.
- ram_read_ready  in  1  read beat valid.
- ram_read  out  1  read command.
- ram_write  out  1  write beat valid.
- ram_writedata  out  64  write beat; mux of granted channel's ch_wdata.
- ram_byteenable  out  8  mux of granted channel's ch_be.
- ch_addr  in  CHANNELS*29  per-channel start address, channel i at [i*29 +: 29].
- ch_burst  in  CHANNELS*BURST_W  per-channel burst length.
- ch_we  in  CHANNELS  1 = write request, 0 = read.
- ch_req  in  CHANNELS  request toggle.
- ch_ack  out  CHANNELS  completion toggle; equals ch_req when channel idle.
- ch_wdata  in  CHANNELS*64  write data of current beat.
- ch_be  in  CHANNELS*8  byte enables of current beat.
- ch_wnext  out  CHANNELS  one-hot, combinational: beat consumed this cycle.
- ch_data  out  64  shared registered read data.
- ch_ready  out  CHANNELS  one-hot read-beat strobe, qualifies ch_data.

## Operation
- Pending request: channel i is pending while ch_req[i] != ch_ack[i].
- Clients must hold ch_addr, ch_burst and ch_we stable while pending.
- Arbiter: round-robin pointer rr starts at 0.
  - In IDLE, the grant goes to the first pending channel at or after rr, wrapping modulo CHANNELS.
  - After the grant, rr = granted+1, wrapping to 0 past CHANNELS-1.
- States:
  - IDLE: on grant, latch channel g, address and burst.
    - ch_burst==0: toggle ch_ack[g] and stay in IDLE. No DDR access.
    - Read: assert ram_read and go to RD.
    - Write: assert ram_write and go to WR.
  - RD: ram_read holds until a cycle with ram_waitrequest low, then deasserts.
    - Each ram_read_ready beat, accepted in any cycle regardless of waitrequest: ch_data <= ram_readdata, ch_ready[g] <= 1 next cycle, beat count +1.
    - On the final beat (count == burst): toggle ch_ack[g] and go to IDLE.
  - WR: ram_write stays high.
    - ch_wnext[g] = ram_write & !ram_waitrequest.
    - Each accepted beat increments the count.
    - After the burst-th accepted beat: drop ram_write, toggle ch_ack[g], go to IDLE.
- ram_burstcnt, ram_addr and the grant stay constant from command issue until return to IDLE.
- Only one transaction is in flight at a time.
- A new toggle on the channel currently being served is not examined until it has completed.
- Beat counter is BURST_W bits and compares exactly against the latched burst. No overflow is possible.

## Timing
- Reset values:
  - ram_read=0, ram_write=0, ram_burstcnt=0, ram_addr=0.
  - ch_ack=0, ch_ready=0, ch_data=0, state=IDLE, rr=0.
- ram_writedata, ram_byteenable and ch_wnext are combinational from the grant. ch_wnext is 0 outside WR.
- Reset asserted mid-transaction aborts immediately to reset values. In-flight DDR beats arriving after reset release are ignored in IDLE.
- Latency, read:
  - ch_req toggle at edge t is seen at t+1, and ram_read is high after edge t+1.
  - ch_ready pulses one cycle after each ram_read_ready.
  - ch_ack toggles in the same cycle as the last ch_ready.
- Latency, write: the client must present the next beat on ch_wdata/ch_be by the clock edge following a ch_wnext pulse.
- Back-to-back: the next grant is issued on the first IDLE cycle after completion, giving one dead cycle between transactions.

## Test plan
- Read, CHANNELS=4: ch1 read burst 4 at 0x1000 with 4 ready beats D0..D3 -> ram_read for exactly one accepted cycle, ram_burstcnt=4, ram_addr=0x1000, four ch_ready[1] pulses carrying D0..D3, ch_ack[1] toggles once.
- Round-robin: ch0, ch2 and ch3 toggle in the same cycle, rr=0 -> service order 0,2,3. Re-toggling ch0 during ch2 service -> order continues 3 then 0.
- Write with stalls: ch2 write burst 3, waitrequest high on the 2nd beat for 2 cycles -> ch_wnext[2] pulses exactly 3 times, ram_writedata/byteenable track ch_wdata[2]/ch_be[2], ram_write drops after beat 3.
- Burst 0: ch3 toggles with ch_burst=0 -> ch_ack[3] toggles within 2 cycles, ram_read/ram_write never assert.
- Waitrequest on read: read command stalled 5 cycles while ram_read_ready beats arrive -> ram_read held high until accepted, every beat still delivered in order.
- Reset mid-burst: reset_n low after 2 of 8 read beats -> all outputs at reset values asynchronously. After release, a new ch0 request is served normally.
